// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequencer for the Gowin rPLL RESET/LOCK handshake.
// Runs on the crystal clock (clkin). It pulses the PLL reset, waits for lock
// with a timeout and bounded retries, and qualifies lock stability. It releases
// the downstream reset (sys_rst_n) only in RUN. A lock loss or a software
// relock request restarts the sequence.
// Optional build macro PLL_SUPV_LOSS_FILTER_EN: in RUN, a lock loss counts only
// after 4 consecutive low cycles of the synchronised lock.

module pll_lock_supervisor #(
   parameter int unsigned RST_PULSE_CYC    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYC = 27000,
   parameter int unsigned LOCK_STABLE_CYC  = 2700,
   parameter int unsigned MAX_RETRIES      = 7,
   parameter int unsigned CNT_W            = 16
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       relock_req,
   output logic       pll_reset,
   output logic       sys_rst_n,
   output logic       locked,
   output logic       fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   typedef enum logic [2:0] {
      StResetPll,
      StWaitLock,
      StStable,
      StRun,
      StFail
   } state_e;

   localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [3:0]       MaxRetries  = 4'(MAX_RETRIES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   logic             lock_meta_q, lock_s_q;
   logic             pll_reset_q, sys_rst_n_q, locked_q, fail_q;
   logic             loss_event;

`ifdef PLL_SUPV_LOSS_FILTER_EN
   // Number of consecutive low lock_s cycles already seen in RUN.
   logic [1:0]       low_q, low_d;
`endif

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= pll_lock;
         lock_s_q    <= lock_meta_q;
      end
   end

   // Lock-loss recognition in RUN (optionally glitch-filtered).
   always_comb begin
      loss_event = 1'b0;
`ifdef PLL_SUPV_LOSS_FILTER_EN
      low_d = '0;
      if (state_q == StRun && !lock_s_q) begin
         if (low_q == 2'd3) begin
            loss_event = 1'b1;
         end else begin
            low_d = low_q + 1'b1;
         end
      end
`else
      loss_event = (state_q == StRun) && !lock_s_q;
`endif
   end

   // Next-state, shared counter and status counters.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      unique case (state_q)
         StResetPll: begin
            if (cnt_q == RstLast) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWaitLock: begin
            if (lock_s_q) begin
               state_d = StStable;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               retry_d = retry_q + 1'b1;
               cnt_d   = '0;
               state_d = (retry_d == MaxRetries) ? StFail : StResetPll;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStable: begin
            // Any low cycle restarts the timeout window; retries are kept.
            if (!lock_s_q) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == StableLast) begin
               state_d = StRun;
               cnt_d   = '0;
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun: begin
            // A loss takes priority over a concurrent relock request.
            if (loss_event) begin
               state_d = StResetPll;
               cnt_d   = '0;
               if (loss_q != 8'hFF) begin
                  loss_d = loss_q + 1'b1;
               end
            end else if (relock_req) begin
               state_d = StResetPll;
               cnt_d   = '0;
            end
         end
         StFail: begin
            if (relock_req) begin
               state_d = StResetPll;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         default: begin
            state_d = StResetPll;
            cnt_d   = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StResetPll;
         cnt_q   <= '0;
         retry_q <= '0;
         loss_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         loss_q  <= loss_d;
      end
   end

`ifdef PLL_SUPV_LOSS_FILTER_EN
   // Glitch filter counter register.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         low_q <= '0;
      end else begin
         low_q <= low_d;
      end
   end
`endif

   // Outputs decoded from the next state so they switch with the state.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         pll_reset_q <= (state_d == StResetPll);
         sys_rst_n_q <= (state_d == StRun);
         locked_q    <= (state_d == StRun);
         fail_q      <= (state_d == StFail);
      end
   end

   assign pll_reset = pll_reset_q;
   assign sys_rst_n = sys_rst_n_q;
   assign locked    = locked_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;

endmodule
